// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if: request/result bundle for the BCD converter.
//   value : 8-bit binary operand from the requester
//   load  : conversion request
//   busy  : conversion in progress
//   done  : one-cycle pulse on result commit
//   bcd   : committed result {hundreds, tens, ones}
interface count_bcd_display_if;
  logic [7:0]  value;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  modport master (output value, output load, input busy, input done, input bcd);
  modport slave  (input value, input load, output busy, output done, output bcd);
endinterface

// File: rtl/count_bcd_display.sv
// count_bcd_display: serial double-dabble binary-to-BCD converter with a
// multiplexed three-digit seven-segment display of the committed result.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of count_bcd_display_if (value/load in, busy/done/bcd out)
//   seg  : segments {g,f,e,d,c,b,a}, active-high, combinational from bcd and digit
//   an   : one-hot digit enable, [0] ones, [1] tens, [2] hundreds
module count_bcd_display #(
  parameter int unsigned SCAN_DIV = 12000,
  parameter bit          BLANK    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  count_bcd_display_if.slave   bus,
  output logic [6:0]           seg,
  output logic [2:0]           an
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    dig_q, dig_d;

  logic [11:0]   adj;
  logic [19:0]   sh;
  logic [3:0]    nib;
  logic          blank_dig;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      pre_q     <= '0;
      dig_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      pre_q     <= pre_d;
      dig_q     <= dig_d;
    end
  end

  // Double-dabble correction: +3 on every nibble >= 5 before the shift.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < 3; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
    end
    sh = {adj, bin_q} << 1;
  end

  // Conversion FSM next-state and outputs.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        // The done cycle is still IDLE; a load there is deliberately dropped.
        if (bus.load && !done_q) begin
          bin_d     = bus.value;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = sh[19:8];
        bin_d     = sh[7:0];
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan, independent of the converter.
  always_comb begin
    pre_d = pre_q + PW'(1);
    dig_d = dig_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end
  end

  // Digit select, leading-zero blanking and segment decode.
  always_comb begin
    an        = 3'b001 << dig_q;
    nib       = bcd_q[3:0];
    blank_dig = 1'b0;
    case (dig_q)
      2'd1: begin
        nib       = bcd_q[7:4];
        blank_dig = BLANK && (bcd_q[11:4] == 8'h00);
      end
      2'd2: begin
        nib       = bcd_q[11:8];
        blank_dig = BLANK && (bcd_q[11:8] == 4'h0);
      end
      default: ;
    endcase
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    if (blank_dig) seg = 7'h00;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: doc/count_bcd_display.md
COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12000, meaning clk cycles per digit-scan step (legal range >= 2).
REQ-002 SHALL have parameter BLANK, default 1, meaning leading-zero blanking enabled (1) or disabled (0).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port value  input  8  unsigned binary value to convert, driven by the 8-bit free-running counter.
REQ-006 SHALL have port load  input  1  conversion request, sampled on rising clk.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a new bcd result is committed.
REQ-009 SHALL have port bcd  output  12  committed result: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-011 SHALL have port an  output  3  one-hot digit enable, active-high: [0] ones, [1] tens, [2] hundreds.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with load=1 at edge N: SHALL capture value, clear the 12-bit scratch, clear the 3-bit shift count, enter SHIFT, and set busy=1.
REQ-014 In IDLE with load=0: SHALL hold all registers.
REQ-015 In SHIFT, each edge SHALL perform one double-dabble step: add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by 1 with the binary MSB entering scratch[0].
REQ-016 SHALL perform exactly 8 SHIFT steps (edges N+1..N+8); at edge N+8 it SHALL enter DONE.
REQ-017 In DONE at edge N+9: SHALL write scratch to bcd, set done=1 for exactly that cycle, clear busy, and return to IDLE.
REQ-018 busy SHALL be high for exactly 9 cycles per conversion; total latency from load sample to bcd valid SHALL be 9 cycles.
REQ-019 load while busy=1 SHALL be ignored, with no queueing; value changes during a conversion SHALL have no effect.
REQ-020 load=1 in the same cycle that done=1 SHALL be ignored; a new load is accepted from the next IDLE cycle.
REQ-021 bcd SHALL change only in DONE; the display SHALL show the old bcd throughout a conversion.
REQ-022 Every bcd nibble SHALL be 0..9; 255 SHALL yield 0x255.
REQ-023 Scan prescaler: SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, the digit index SHALL advance 0->1->2->0.
REQ-024 an SHALL equal the one-hot encoding of the digit index, with exactly one bit set at all times.
REQ-025 seg SHALL be combinational from registered bcd and digit index: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-026 Blanking (BLANK=1): hundreds SHALL be blanked (seg=00) when it is 0; tens SHALL be blanked when hundreds and tens are both 0; ones SHALL never be blanked.
REQ-027 With BLANK=0, no digit SHALL be blanked.
REQ-028 The scan SHALL run independently of the conversion FSM and SHALL never stall.

Reset
REQ-029 rst=1 at an edge SHALL force: state IDLE, busy=0, done=0, bcd=000, scratch=0, shift count=0, prescaler=0, digit index=0 (an=001, seg=3F).
REQ-030 rst SHALL take priority over load and over any in-flight conversion; an aborted conversion SHALL NOT update bcd or pulse done.
REQ-031 rst=1 held over several edges SHALL keep all outputs at their reset values.

Verification
REQ-032 value=255, load pulse -> busy high 9 cycles, then bcd=0x255 with done high for 1 cycle.
REQ-033 value=0, 9, 10, 99, 100 in turn -> bcd=000/009/010/099/100; with BLANK=1 the digits lit are 1/1/2/2/3.
REQ-034 load again at cycles N+3 and N+9 with different values -> both ignored; bcd reflects only the first value.
REQ-035 SCAN_DIV=4 -> an sequence 001,010,100,001 with each step lasting exactly 4 cycles; seg matches the displayed digit (bcd=0x128: 06, 5B, 7F).
REQ-036 rst asserted at N+5 mid-conversion -> busy=0 next edge, done never pulses, bcd=000, an=001.
REQ-037 Back-to-back: load accepted in the first IDLE cycle after done -> second result committed 9 cycles later, with no lost or duplicated done pulse.
